// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the RV32IM pipeline.
// Issues one ready-handshaked data-memory access per load/store held in
// EX/MEM, steers byte/halfword lanes, extends load data and drives the
// MEM/WB write-back fields. Non-memory instructions pass straight through.
//
// Handshake: mem_req and its fields (mem_we, mem_addr, mem_wdata,
// mem_byte_en) are registered and held stable from issue until the access
// ends. The transfer completes on any ACCESS cycle with mem_ready = 1;
// mem_req drops on the following cycle. mem_ready outside ACCESS is ignored.
// If mem_ready never arrives within TIMEOUT_CYCLES ACCESS cycles the access
// is abandoned and Bus_error pulses for the DONE cycle.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Store_Data,
  input  logic        Write_enable,
  input  logic [4:0]  Write_Address,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        Stall,
  output logic        Write_Enable_Out,
  output logic        Memory_access_Out,
  output logic [31:0] Memory_Data_Out,
  output logic [31:0] ALU_Output_Out,
  output logic [4:0]  Write_Address_out,
  output logic        Misaligned,
  output logic        Bus_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mdo_q, mdo_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_error_q, bus_error_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;

  logic        op;
  logic        mis_raw;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        stall_c;

  assign op = Mem_read | Mem_write;

  // Alignment fault detection for the access size encoded in Funct3.
  always_comb begin
    mis_raw = 1'b0;
    case (Funct3)
      3'b000, 3'b100: mis_raw = 1'b0;
      3'b001, 3'b101: mis_raw = ALU_Result[0];
      3'b010:         mis_raw = |ALU_Result[1:0];
      default:        mis_raw = 1'b1;
    endcase
  end

  // Store lane steering: replicate data across lanes, enable only the target bytes.
  always_comb begin
    req_wdata = 32'h0;
    req_be    = 4'b1111;
    if (Mem_write) begin
      case (Funct3[1:0])
        2'b00: begin
          req_wdata = {4{Store_Data[7:0]}};
          req_be    = 4'b0001 << ALU_Result[1:0];
        end
        2'b01: begin
          req_wdata = {2{Store_Data[15:0]}};
          req_be    = ALU_Result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          req_wdata = Store_Data;
          req_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the size/offset latched at issue.
  always_comb begin
    ld_byte = 8'h0;
    case (ld_lo_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = mem_rdata;
    case (ld_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and request-register logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mdo_d       = mdo_q;
    wait_cnt_d  = wait_cnt_q;
    bus_error_d = 1'b0;
    is_load_d   = is_load_q;
    ld_f3_d     = ld_f3_q;
    ld_lo_d     = ld_lo_q;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op && !mis_raw) begin
          stall_c     = 1'b1;
          state_d     = S_ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = Mem_write;
          mem_addr_d  = {ALU_Result[31:2], 2'b00};
          mem_wdata_d = req_wdata;
          mem_be_d    = req_be;
          wait_cnt_d  = 8'd0;
          is_load_d   = ~Mem_write;
          ld_f3_d     = Funct3;
          ld_lo_d     = ALU_Result[1:0];
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          if (is_load_q) mdo_d = ld_ext;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and request registers; synchronous reset abandons any access.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      mdo_q       <= 32'h0;
      wait_cnt_q  <= 8'd0;
      bus_error_q <= 1'b0;
      is_load_q   <= 1'b0;
      ld_f3_q     <= 3'b000;
      ld_lo_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mdo_q       <= mdo_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
      is_load_q   <= is_load_d;
      ld_f3_q     <= ld_f3_d;
      ld_lo_q     <= ld_lo_d;
    end
  end

  // Write-back fields: combinational passthrough with fault overrides.
  always_comb begin
    Misaligned        = op & mis_raw;
    Write_Enable_Out  = Write_enable & ~Misaligned & ~bus_error_q;
    Memory_access_Out = Mem_read & ~Mem_write;
    ALU_Output_Out    = ALU_Result;
    Write_Address_out = Write_Address;
  end

  assign Stall           = stall_c;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_en     = mem_be_q;
  assign Memory_Data_Out = mdo_q;
  assign Bus_error       = bus_error_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed load/store/fault scenarios with a
// behavioural expectation model and a per-cycle compare process.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Mem_read, Mem_write;
  logic [2:0]  Funct3;
  logic [31:0] ALU_Result, Store_Data;
  logic        Write_enable;
  logic [4:0]  Write_Address;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        Stall, Write_Enable_Out, Memory_access_Out;
  logic [31:0] Memory_Data_Out, ALU_Output_Out;
  logic [4:0]  Write_Address_out;
  logic        Misaligned, Bus_error;
  logic [1:0]  dbg_state;

  // clock / reset block
  always #5 CLK = ~CLK;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .Reset(Reset),
    .Mem_read(Mem_read), .Mem_write(Mem_write), .Funct3(Funct3),
    .ALU_Result(ALU_Result), .Store_Data(Store_Data),
    .Write_enable(Write_enable), .Write_Address(Write_Address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .Stall(Stall), .Write_Enable_Out(Write_Enable_Out),
    .Memory_access_Out(Memory_access_Out), .Memory_Data_Out(Memory_Data_Out),
    .ALU_Output_Out(ALU_Output_Out), .Write_Address_out(Write_Address_out),
    .Misaligned(Misaligned), .Bus_error(Bus_error), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic f_mis(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = a[0];
      3'b010:         bad = (a[1:0] != 2'b00);
      default:        bad = 1'b1;
    endcase
    return (rd | wr) & bad;
  endfunction

  function automatic logic [3:0] f_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (!wr) return 4'hF;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      case (a[1:0])
        2'd0: return 4'h1;
        2'd1: return 4'h2;
        2'd2: return 4'h4;
        default: return 4'h8;
      endcase
    end
    if (f3 == 3'b001 || f3 == 3'b101) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] sd);
    if (!wr) return 32'h0;
    if (f3 == 3'b000 || f3 == 3'b100) return {4{sd[7:0]}};
    if (f3 == 3'b001 || f3 == 3'b101) return {2{sd[15:0]}};
    return sd;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] t;
    logic [7:0]  b;
    logic [15:0] h;
    int sh;
    sh = int'(a[1:0]) * 8;
    t  = w >> sh;
    b  = t[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- expectations / scoreboard ----------------
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_berr, exp_pop;
  logic        exp_wen, exp_ma, exp_mis, exp_mwe;
  logic [31:0] exp_alu, exp_maddr, exp_mwdata, exp_mdo;
  logic [4:0]  exp_wa;
  logic [3:0]  exp_mbe;
  logic [31:0] exp_q[$];

  // compare process: checks every cycle the outputs are meaningful
  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall", 32'(Stall), 32'(exp_stall));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("bus_error", 32'(Bus_error), 32'(exp_berr));
      check("wen_out", 32'(Write_Enable_Out), 32'(exp_wen));
      check("macc_out", 32'(Memory_access_Out), 32'(exp_ma));
      check("misaligned", 32'(Misaligned), 32'(exp_mis));
      check("alu_out", ALU_Output_Out, exp_alu);
      check("wa_out", 32'(Write_Address_out), 32'(exp_wa));
      check("mdo", Memory_Data_Out, exp_mdo);
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_mwe));
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_wdata", mem_wdata, exp_mwdata);
        check("mem_be", 32'(mem_byte_en), 32'(exp_mbe));
      end
      if (exp_pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL exp_q: load result expected but queue empty at %0t", $time);
        end else begin
          check("load_capture", Memory_Data_Out, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        ma;
    logic [31:0] mdo;
    logic        berr;
    logic        wen;
    int          stall_cyc;
    int          req_cyc;
  } snap_t;

  task automatic drive_in(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] wa, input logic we);
    Mem_read      = rd;
    Mem_write     = wr;
    Funct3        = f3;
    ALU_Result    = a;
    Store_Data    = sd;
    Write_Address = wa;
    Write_enable  = we;
    exp_alu = a;
    exp_wa  = wa;
    exp_ma  = rd & ~wr;
    exp_mis = f_mis(rd, wr, f3, a);
    exp_wen = we & ~exp_mis;
  endtask

  task automatic set_nop();
    drive_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_berr  = 1'b0;
    exp_pop   = 1'b0;
  endtask

  // Runs one aligned memory op from issue through DONE plus one idle cycle.
  // ready_delay: ACCESS cycle index at which mem_ready rises; -1 = never.
  task automatic do_mem(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] wa, input logic we,
                        input logic [31:0] rdata, input int ready_delay,
                        output snap_t s);
    logic got;
    s = '{default: 0};
    got = 1'b0;
    drive_in(rd, wr, f3, a, sd, wa, we);
    exp_stall  = 1'b1;
    exp_req    = 1'b0;
    exp_berr   = 1'b0;
    exp_pop    = 1'b0;
    exp_mwe    = wr;
    exp_maddr  = {a[31:2], 2'b00};
    exp_mwdata = f_wdata(wr, f3, sd);
    exp_mbe    = f_be(wr, f3, a);
    mem_ready  = 1'b1;              // stray ready while idle must be ignored
    mem_rdata  = 32'hDEADBEEF;
    @(negedge CLK);
    s.stall_cyc += int'(Stall);
    s.req_cyc   += int'(mem_req);
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    exp_req   = 1'b1;
    for (int k = 0; k < TO; k++) begin
      if (k == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge CLK);
      s.stall_cyc += int'(Stall);
      s.req_cyc   += int'(mem_req);
      if (k == 0) begin
        s.be    = mem_byte_en;
        s.wdata = mem_wdata;
        s.we    = mem_we;
        s.ma    = Memory_access_Out;
      end
      @(posedge CLK); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (k == ready_delay) begin
        got = 1'b1;
        break;
      end
    end
    // DONE cycle
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_berr  = ~got;
    exp_wen   = we & got;
    if (got && !wr) begin
      exp_q.push_back(f_load(f3, a, rdata));
      exp_mdo = f_load(f3, a, rdata);
      exp_pop = 1'b1;
    end
    mem_ready = 1'b1;               // stray ready in DONE must be ignored
    mem_rdata = 32'hCAFEF00D;
    @(negedge CLK);
    s.stall_cyc += int'(Stall);
    s.req_cyc   += int'(mem_req);
    s.mdo  = Memory_Data_Out;
    s.berr = Bus_error;
    s.wen  = Write_Enable_Out;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    set_nop();
    @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    snap_t s;
    Reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    set_nop();
    exp_mdo = 32'h0;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_byte_en), 32'h0);
    check("rst_mdo", Memory_Data_Out, 32'h0);
    check("rst_bus_error", 32'(Bus_error), 32'h0);
    check("rst_stall", 32'(Stall), 32'h0);
    @(posedge CLK); #1;
    chk_en = 1'b1;

    // LB at 0x1003, ready in first ACCESS cycle
    do_mem(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 32'h80FF_1234, 0, s);
    check("lb_be", 32'(s.be), 32'h0000_000F);
    check("lb_mdo", s.mdo, 32'hFFFF_FF80);
    check("lb_stall_cycles", 32'(s.stall_cyc), 32'd2);
    check("lb_model_pin", f_load(3'b000, 32'h0000_1003, 32'h80FF_1234), 32'hFFFF_FF80);

    // LBU on the same inputs
    do_mem(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 32'h80FF_1234, 0, s);
    check("lbu_mdo", s.mdo, 32'h0000_0080);

    // SH at 0x2002
    do_mem(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_5678, 5'd0, 1'b0, 32'h0, 0, s);
    check("sh_wdata", s.wdata, 32'h5678_5678);
    check("sh_be", 32'(s.be), 32'h0000_000C);
    check("sh_we", 32'(s.we), 32'h1);
    check("sh_macc", 32'(s.ma), 32'h0);
    check("sh_mdo_unchanged", s.mdo, 32'h0000_0080);

    // LW misaligned at 0x3001: no access, no stall
    drive_in(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd7, 1'b1);
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("lw_mis_flag", 32'(Misaligned), 32'h1);
      check("lw_mis_req", 32'(mem_req), 32'h0);
      check("lw_mis_stall", 32'(Stall), 32'h0);
      check("lw_mis_wen", 32'(Write_Enable_Out), 32'h0);
      @(posedge CLK); #1;
    end
    set_nop();

    // Reserved Funct3 with a store is also a fault
    drive_in(1'b0, 1'b1, 3'b111, 32'h0000_3000, 32'h1, 5'd0, 1'b0);
    @(negedge CLK);
    check("rsvd_f3_mis", 32'(Misaligned), 32'h1);
    @(posedge CLK); #1;
    set_nop();

    // ADD passthrough
    drive_in(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
    @(negedge CLK);
    check("add_alu", ALU_Output_Out, 32'h0000_0042);
    check("add_wa", 32'(Write_Address_out), 32'd5);
    check("add_wen", 32'(Write_Enable_Out), 32'h1);
    check("add_stall", 32'(Stall), 32'h0);
    check("add_req", 32'(mem_req), 32'h0);
    @(posedge CLK); #1;
    set_nop();

    // LW timeout with TIMEOUT_CYCLES = 4
    do_mem(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd9, 1'b1, 32'h0, -1, s);
    check("to_req_cycles", 32'(s.req_cyc), 32'd4);
    check("to_stall_cycles", 32'(s.stall_cyc), 32'd5);
    check("to_bus_error", 32'(s.berr), 32'h1);
    check("to_wen", 32'(s.wen), 32'h0);
    check("to_mdo_unchanged", s.mdo, 32'h0000_0080);

    // Halfword loads and byte/word stores
    do_mem(1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0, 5'd10, 1'b1, 32'h8001_7FFF, 1, s);
    check("lh_mdo", s.mdo, 32'hFFFF_8001);
    check("lh_stall_cycles", 32'(s.stall_cyc), 32'd3);
    do_mem(1'b1, 1'b0, 3'b101, 32'h0000_6000, 32'h0, 5'd11, 1'b1, 32'h8001_7FFF, 0, s);
    check("lhu_mdo", s.mdo, 32'h0000_7FFF);
    do_mem(1'b0, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 5'd0, 1'b0, 32'h0, 2, s);
    check("sb_wdata", s.wdata, 32'hA5A5_A5A5);
    check("sb_be", 32'(s.be), 32'h0000_0002);
    do_mem(1'b1, 1'b1, 3'b010, 32'h0000_7000, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 0, s);
    check("sw_both_wdata", s.wdata, 32'h1234_5678);
    check("sw_both_be", 32'(s.be), 32'h0000_000F);
    check("sw_both_macc", 32'(s.ma), 32'h0);

    // Reset during ACCESS: EX/MEM is flushed alongside, ready in reset cycle ignored
    chk_en = 1'b0;
    drive_in(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd12, 1'b1);
    @(posedge CLK); #1;              // ACCESS cycle 1
    @(posedge CLK); #1;              // ACCESS cycle 2
    Reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    set_nop();
    @(negedge CLK);
    check("rst_pre_req", 32'(mem_req), 32'h1);
    @(posedge CLK); #1;
    Reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    @(negedge CLK);
    check("rst_acc_req", 32'(mem_req), 32'h0);
    check("rst_acc_state", 32'(dbg_state), 32'h0);
    check("rst_acc_mdo", Memory_Data_Out, 32'h0);
    check("rst_acc_stall", 32'(Stall), 32'h0);
    @(posedge CLK); #1;
    exp_mdo = 32'h0;
    chk_en  = 1'b1;

    // Normal LW after reset, two wait cycles
    do_mem(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd13, 1'b1, 32'h1122_3344, 2, s);
    check("lw_mdo", s.mdo, 32'h1122_3344);
    check("lw_stall_cycles", 32'(s.stall_cyc), 32'd4);
    check("lw_wen", 32'(s.wen), 32'h1);

    chk_en = 1'b0;
    @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
